instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction fetch front end for the single-cycle RISC-V core. Produces the instruction stream consumed by the main control decoder (opcode bits [6:2]) and by the immediate/register decode logic. Owns the PC register, issues word reads to instruction memory over a req/gnt/rvalid handshake, and buffers returned words in a small FIFO. Accepts redirects (taken branch, JAL, JALR) from execute and discards stale in-flight data.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset; synchronous, active-low
imem_req  out  1  read request to instruction memory
imem_addr  out  XLEN  word-aligned fetch address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  read data valid (exactly one per granted request, >=1 cycle after gnt)
imem_rdata  in  XLEN  returned instruction word
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_instr  out  32  instruction word at FIFO head
if_opcode  out  5  if_instr[6:2], drives control decoder input
if_pc  out  XLEN  PC of if_instr
id_ready  in  1  decode consumes head when if_valid && id_ready
redir_valid  in  1  redirect request (branch taken / jump)
redir_pc  in  XLEN  redirect target
fetch_misalign  out  1  sticky: redirect target not 4-byte aligned

Behaviour:
- Reset (rst_n low at clk edge): fetch_pc=RESET_PC, FIFO empty, outstanding=0, state IDLE, imem_req=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=0, fetch_misalign=0.
- FSM: IDLE -> REQ next cycle after reset release. REQ: imem_req=1 when (fifo_count + outstanding) < BUF_DEPTH; on gnt: outstanding=1, fetch_pc+=4, -> WAIT. WAIT: on rvalid push {rdata, pc} to FIFO, outstanding=0, -> REQ. DROP: on rvalid discard data, outstanding=0, -> REQ.
- At most one outstanding request. imem_addr = fetch_pc, stable while imem_req=1 and not granted.
- PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0, no flag.
- Push/pop: head pops when if_valid && id_ready; push on rvalid in WAIT. Simultaneous push and pop when full is legal (count unchanged). No push when full (prevented by issue rule).
- Zero-bubble latency: rvalid in cycle N -> if_valid in N+1 (registered FIFO output). No combinational path rvalid->if_valid or id_ready->imem_req.
- Redirect (highest priority, any state): FIFO flushed, if_valid=0 next cycle, fetch_pc=redir_pc. If outstanding (WAIT, or REQ with gnt same cycle) -> DROP, else -> REQ. Pop in redirect cycle is discarded.
- Redirect with redir_pc[1:0]!=0: fetch_misalign set (sticky until reset), state IDLE, no further requests.
- Redirect during DROP: update fetch_pc, remain DROP.
- rvalid in REQ/IDLE with outstanding=0: ignored (protocol error).
- Reset mid-transaction: all state cleared; late rvalid after reset ignored (outstanding=0).

Optional Feature:
IFU_PERF_CNT_EN: adds outputs perf_fetched[31:0] (words pushed) and perf_dropped[31:0] (words discarded in DROP plus entries flushed), reset to 0, saturating at 32'hFFFF_FFFF. Without macro: ports and counters absent, behaviour otherwise identical.

Decomposition:
- Shared package (riscv_pkg): opcode constants for [6:2] (OP_R=5'b01100, OP_LOAD=5'b00000, OP_STORE=5'b01000, OP_BRANCH=5'b11000, OP_JAL=5'b11011, OP_JALR=5'b11001, OP_AUIPC=5'b00101, OP_LUI=5'b01101), NOP encoding 32'h0000_0013, fetch state enum.
- One sub-module: ifu_fifo (parameterised depth, width XLEN+32, push/pop/flush, count output).

Test Plan:
- Reset release, imem gnt same cycle, rvalid 1 cycle later returning 0x00000013,0x00A00093 -> if_pc 0x0,0x4 in order; if_opcode 5'b00100; first if_valid 3 cycles after reset release.
- id_ready held 0 -> exactly BUF_DEPTH words fetched, imem_req drops; release id_ready -> requests resume, no duplicates or gaps in if_pc.
- Redirect to 0x100 while WAIT pending for 0x8 -> stale word dropped, next if_pc=0x100, FIFO empty 1 cycle after redirect.
- Redirect to 0x102 -> fetch_misalign=1, imem_req stays 0 until reset.
- fetch_pc=0xFFFF_FFFC via redirect -> next imem_addr 0x0000_0000.
- rst_n low while outstanding, rvalid arrives next cycle -> ignored, first fetch from RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: major-opcode field values (instr[6:2]),
// the canonical NOP encoding and the fetch FSM state type.
package riscv_pkg;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: req/gnt address phase, rvalid/rdata data phase.
// The fetch unit is the master; the memory (or its model) is the slave.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ifu_fifo.sv
// Instruction buffer: power-of-two deep FIFO with flush and occupancy count.
// Head is read from registered storage, so nothing combinational reaches the outputs.
module ifu_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 64,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    // Push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; count gates validity, and a reset-free array maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, keeps one imem read in flight, buffers words for decode.
// Define IFU_PERF_CNT_EN to add saturating perf_fetched / perf_dropped counters.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master imem,
    output logic               if_valid,
    output logic [31:0]        if_instr,
    output logic [4:0]         if_opcode,
    output logic [XLEN-1:0]    if_pc,
    input  logic               id_ready,
    input  logic               redir_valid,
    input  logic [XLEN-1:0]    redir_pc,
    output logic               fetch_misalign
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_dropped
`endif
);
    localparam int              CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_t     state;
    logic [XLEN-1:0]  fetch_pc;
    logic             outstanding;
    logic [CW-1:0]    fifo_count;
    logic [XLEN+31:0] head;
    logic             granted;
    logic             push;
    logic             pop;
    logic             outstanding_after;

    // Issue only when the returning word is guaranteed a free slot.
    assign imem.imem_req  = (state == ST_REQ) &&
                            ((int'(fifo_count) + int'(outstanding)) < BUF_DEPTH);
    assign imem.imem_addr = fetch_pc;

    assign granted           = imem.imem_req && imem.imem_gnt;
    assign push              = (state == ST_WAIT) && imem.imem_rvalid && !redir_valid;
    assign pop               = if_valid && id_ready && !redir_valid;
    assign outstanding_after = (outstanding && !imem.imem_rvalid) || granted;

    // fetch_pc already advanced on grant, so the in-flight word belongs to fetch_pc - 4.
    ifu_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN + 32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({imem.imem_rdata[31:0], fetch_pc - PC_STEP}),
        .pop       (pop),
        .flush     (redir_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign if_valid  = (fifo_count != '0);
    assign if_instr  = if_valid ? head[XLEN +: 32] : NOP_INSTR;
    assign if_pc     = if_valid ? head[XLEN-1:0] : '0;
    assign if_opcode = if_instr[6:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            fetch_pc       <= RESET_PC;
            outstanding    <= 1'b0;
            fetch_misalign <= 1'b0;
        end else begin
            outstanding <= outstanding_after;
            if (fetch_misalign) begin
                state <= ST_IDLE;
            end else if (redir_valid) begin
                fetch_pc <= redir_pc;
                if (redir_pc[1:0] != 2'b00) begin
                    fetch_misalign <= 1'b1;
                    state          <= ST_IDLE;
                end else begin
                    state <= outstanding_after ? ST_DROP : ST_REQ;
                end
            end else begin
                unique case (state)
                    ST_IDLE: state <= ST_REQ;
                    ST_REQ: begin
                        if (granted) begin
                            fetch_pc <= fetch_pc + PC_STEP;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT, ST_DROP: begin
                        if (imem.imem_rvalid) state <= ST_REQ;
                    end
                endcase
            end
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic        discarded;
    logic [32:0] fetched_sum;
    logic [32:0] dropped_sum;

    // Any returned word that does not land in the buffer counts as dropped.
    assign discarded   = imem.imem_rvalid && outstanding && !push;
    assign fetched_sum = {1'b0, perf_fetched} + 33'(push);
    assign dropped_sum = {1'b0, perf_dropped} + 33'(discarded) +
                         (redir_valid ? 33'(fifo_count) : 33'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            perf_dropped <= dropped_sum[32] ? '1 : dropped_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a latency-configurable imem model answers
// requests, and every consumed instruction is checked against the memory contents.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  op;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [4:0]  if_opcode;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        fetch_misalign;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;
`endif

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .id_ready       (id_ready),
        .redir_valid    (redir_valid),
        .redir_pc       (redir_pc),
        .fetch_misalign (fetch_misalign)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_dropped   (perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    int          checks    = 0;
    int          failures  = 0;
    int          lat       = 1;
    bit          pend      = 1'b0;
    int          cnt       = 0;
    logic [31:0] paddr     = '0;
    int          gnt_count = 0;
    int          req_cycles = 0;
    logic        last_gnt  = 1'b0;
    logic [31:0] last_gnt_addr = '0;
    rec_t        got[$];

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0000_0000: return 32'h0000_0013;
            32'h0000_0004: return 32'h00A0_0093;
            default:       return {addr[23:0], 8'h33};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One clock: record a consumed head, then act as the memory for the new cycle.
    task automatic tick();
        rec_t r;
        if (if_valid && id_ready && !redir_valid) begin
            r.pc    = if_pc;
            r.instr = if_instr;
            r.op    = if_opcode;
            got.push_back(r);
        end
        @(posedge clk);
        #1;
        bus.imem_rvalid = 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(paddr);
                pend            = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (bus.imem_req) req_cycles++;
        bus.imem_gnt  = bus.imem_req && !pend;
        last_gnt      = bus.imem_gnt;
        last_gnt_addr = bus.imem_addr;
        if (bus.imem_gnt) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = bus.imem_addr;
            gnt_count++;
        end
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        tick();
        tick();
        check({tag, "_misalign"}, fetch_misalign, 0);
        check({tag, "_valid"}, if_valid, 0);
        check({tag, "_req"}, bus.imem_req, 0);
        gnt_count = 0;
        got.delete();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        tick();
        redir_valid = 1'b0;
        got.delete();
    endtask

    task automatic run_collect(input string tag, input int n, input int budget);
        int k = 0;
        while (got.size() < n && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_collect"}, got.size(), n);
    endtask

    task automatic wait_grant(input string tag, input logic [31:0] addr, input int budget);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!(last_gnt && last_gnt_addr == addr) && k < budget);
        check({tag, "_grant"}, last_gnt && (last_gnt_addr == addr), 1);
    endtask

    // Consumed stream must be consecutive words from start, with matching contents.
    task automatic check_seq(input string tag, input logic [31:0] start, input int n);
        logic [31:0] pc;
        logic [31:0] w;
        for (int i = 0; i < n && i < got.size(); i++) begin
            pc = start + 32'(4 * i);
            w  = mem_word(pc);
            check($sformatf("%s_pc%0d", tag, i), got[i].pc, pc);
            check($sformatf("%s_instr%0d", tag, i), got[i].instr, w);
            check($sformatf("%s_op%0d", tag, i), {27'b0, got[i].op}, {27'b0, w[6:2]});
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        id_ready        = 1'b0;
        redir_valid     = 1'b0;
        redir_pc        = '0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;

        // Reset values and first-fetch latency.
        repeat (3) tick();
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_pc", if_pc, 32'h0);
        check("rst_valid", if_valid, 0);
        check("rst_req", bus.imem_req, 0);
        check("rst_misalign", fetch_misalign, 0);
        id_ready = 1'b1;
        rst_n    = 1'b1;
        tick();
        check("t1_req_c1", bus.imem_req, 1);
        check("t1_addr_c1", bus.imem_addr, 32'h0);
        check("t1_valid_c1", if_valid, 0);
        tick();
        check("t1_valid_c2", if_valid, 0);
        check("t1_req_wait", bus.imem_req, 0);
        tick();
        check("t1_valid_c3", if_valid, 1);
        check("t1_head_pc", if_pc, 32'h0);
        check("t1_head_instr", if_instr, 32'h0000_0013);
        check("t1_head_op", {27'b0, if_opcode}, 32'b00100);
        got.delete();
        run_collect("t1", 4, 40);
        check_seq("t1", 32'h0, 4);

        // Backpressure: buffer fills, requests stop, then resume without gaps.
        do_reset("t2_rst");
        id_ready = 1'b0;
        repeat (12) tick();
        check("t2_grants", gnt_count, 2);
        check("t2_req_full", bus.imem_req, 0);
        check("t2_valid_full", if_valid, 1);
        check("t2_head_full", if_pc, 32'h0);
        id_ready = 1'b1;
        got.delete();
        run_collect("t2", 6, 60);
        check_seq("t2", 32'h0, 6);

        // Redirect while the read for 0x8 is in flight.
        do_reset("t3_rst");
        lat = 3;
        wait_grant("t3", 32'h8, 100);
        tick();
        redirect(32'h0000_0100);
        check("t3_valid_flush", if_valid, 0);
        check("t3_req_drop", bus.imem_req, 0);
        tick();
        check("t3_req_drop2", bus.imem_req, 0);
        tick();
        check("t3_req_resume", bus.imem_req, 1);
        check("t3_addr_resume", bus.imem_addr, 32'h0000_0100);
        run_collect("t3", 2, 40);
        check_seq("t3", 32'h0000_0100, 2);

        // PC wrap from the top of the address space.
        lat = 1;
        redirect(32'hFFFF_FFFC);
        run_collect("t4", 2, 40);
        check_seq("t4", 32'hFFFF_FFFC, 2);

        // Misaligned target halts fetching until reset, even across a later redirect.
        req_cycles = 0;
        redirect(32'h0000_0102);
        check("t5_misalign", fetch_misalign, 1);
        check("t5_valid", if_valid, 0);
        repeat (10) tick();
        redirect(32'h0000_0200);
        repeat (10) tick();
        check("t5_req_cycles", req_cycles, 0);
        check("t5_misalign_sticky", fetch_misalign, 1);
        check("t5_valid_end", if_valid, 0);

        // Reset with a read outstanding; its late return must be ignored.
        do_reset("t6_rst");
        lat = 2;
        wait_grant("t6", 32'h8, 100);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_late_rvalid", bus.imem_rvalid, 1);
        check("t6_valid_rst", if_valid, 0);
        check("t6_req_rst", bus.imem_req, 0);
        tick();
        check("t6_valid_after", if_valid, 0);
        check("t6_req_after", bus.imem_req, 1);
        check("t6_addr_after", bus.imem_addr, 32'h0);
        got.delete();
        run_collect("t6", 2, 40);
        check_seq("t6", 32'h0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
